// File: rtl/fifo_push_arbiter_if.sv
// fifo_push_arbiter_if: source request/byte lanes plus FIFO write-side signals.
// The master modport belongs to the sources and FIFO; the slave modport belongs to the arbiter.
interface fifo_push_arbiter_if #(parameter int N_REQ = 4);
    logic [N_REQ-1:0]   req;
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_last;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ-1:0]   gnt;
    logic               fifo_full;
    logic               fifo_push;
    logic [7:0]         fifo_wdata;
    logic               busy;
    logic               abort;

    modport master (
        output req, req_valid, req_last, req_data, fifo_full,
        input  req_ready, gnt, fifo_push, fifo_wdata, busy, abort
    );

    modport slave (
        input  req, req_valid, req_last, req_data, fifo_full,
        output req_ready, gnt, fifo_push, fifo_wdata, busy, abort
    );
endinterface

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: round-robin, packet-locked sharing of one FIFO push port among N_REQ sources.
// Define ARB_TIMEOUT_EN to release a grant stalled for TIMEOUT cycles, pulsing abort.
module fifo_push_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    fifo_push_arbiter_if.slave  bus
);
    localparam int IW = $clog2(N_REQ);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           r_state, w_next;
    logic [N_REQ-1:0] r_gnt;
    logic [IW-1:0]    r_idx, r_last, w_pick, w_cand;
    logic             w_any, w_valid, w_last, w_push, w_to, w_end;
    logic [7:0]       w_data;

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
        $error("fifo_push_arbiter: parameter out of range");
    end

    // Descending scan so the nearest requester after r_last is the one kept.
    always_comb begin
        w_pick = r_last;
        w_cand = '0;
        w_any  = 1'b0;
        for (int i = N_REQ; i >= 1; i--) begin
            w_cand = IW'((int'(r_last) + i) % N_REQ);
            if (bus.req[w_cand]) begin
                w_pick = w_cand;
                w_any  = 1'b1;
            end
        end
    end

    always_comb begin
        w_data = '0;
        for (int i = 0; i < N_REQ; i++)
            if (r_gnt[i]) w_data = bus.req_data[8*i +: 8];
    end

    assign w_valid = |(bus.req_valid & r_gnt);
    assign w_last  = |(bus.req_last & r_gnt);
    assign w_push  = w_valid & ~bus.fifo_full & ~w_to;
    assign w_end   = (w_push & w_last) | w_to;
    assign w_next  = (r_state == IDLE) ? (w_any ? GRANT : IDLE) : (w_end ? IDLE : GRANT);

    assign bus.req_ready  = r_gnt & {N_REQ{~bus.fifo_full & ~w_to}};
    assign bus.gnt        = r_gnt;
    assign bus.fifo_push  = w_push;
    assign bus.fifo_wdata = w_data;
    assign bus.busy       = (r_state == GRANT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_idx   <= '0;
            r_last  <= IW'(N_REQ - 1);
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_any) begin
                r_gnt <= {{(N_REQ-1){1'b0}}, 1'b1} << w_pick;
                r_idx <= w_pick;
            end else if (r_state == GRANT && w_end) begin
                r_gnt  <= '0;
                r_last <= r_idx;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [15:0] r_cnt;
    logic        r_abort;

    assign w_to      = (r_state == GRANT) && (r_cnt == 16'(TIMEOUT));
    assign bus.abort = r_abort;

    // Cleared while idle, so every grant starts counting from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_abort <= 1'b0;
        end else begin
            r_cnt   <= (r_state == GRANT && !w_push) ? r_cnt + 16'd1 : 16'd0;
            r_abort <= w_to;
        end
    end
`else
    assign w_to      = 1'b0;
    assign bus.abort = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb_fifo_push_arbiter: randomized sources and FIFO backpressure, checked by a
// cycle-level reference model plus per-source expected-byte scoreboard queues.
module tb_fifo_push_arbiter;
    localparam int N  = 4;
    localparam int TO = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_push_arbiter_if #(.N_REQ(N)) bus();

    fifo_push_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [8:0] src_q [N][$];
    logic [8:0] exp_q [N][$];
    int valid_pct = 100;
    int full_pct = 0;
    int full_hold = 0;
    logic [N-1:0] vblock = '0;
    int npush = 0;
    int naborts = 0;
    int gq[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(string name);
        checks++;
        errors++;
        $display("FAIL %s: condition not met at %0t", name, $time);
    endtask

    function automatic int rr(logic [N-1:0] r, int last);
        for (int k = 1; k <= N; k++)
            if (r[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    function automatic bit pending();
        for (int i = 0; i < N; i++)
            if (src_q[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic enq(int s, int n, int base);
        for (int j = 0; j < n; j++) begin
            logic [8:0] b;
            b[8]   = (j == n - 1);
            b[7:0] = (base < 0) ? 8'($urandom) : 8'(base + j);
            src_q[s].push_back(b);
            exp_q[s].push_back(b);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(int lim);
        int t = 0;
        while (t < lim && (pending() || bus.busy)) begin
            @(negedge clk);
            t++;
        end
        if (t >= lim) fail_now("drain_timeout");
    endtask

    task automatic wait_push(int lim);
        int p = npush;
        int t = 0;
        while (npush == p && t < lim) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= lim) fail_now("push_timeout");
    endtask

    // Source behaviour: request while bytes are queued, offer the head byte,
    // drop it once it was accepted on a clock edge outside reset.
    initial begin
        logic [N-1:0] acc;
        logic rs;
        bus.req = '0;
        bus.req_valid = '0;
        bus.req_last = '0;
        bus.req_data = '0;
        bus.fifo_full = 1'b0;
        forever begin
            @(negedge clk);
            acc = bus.req_ready & bus.req_valid;
            @(posedge clk);
            rs = rst_n;
            #1;
            for (int i = 0; i < N; i++) begin
                if (rs && acc[i]) void'(src_q[i].pop_front());
                bus.req[i] = (src_q[i].size() != 0);
                bus.req_valid[i] = bus.req[i] && !vblock[i] && ($urandom_range(99) < valid_pct);
                bus.req_last[i] = bus.req[i] ? src_q[i][0][8] : 1'b0;
                bus.req_data[8*i +: 8] = bus.req[i] ? src_q[i][0][7:0] : 8'h00;
            end
            bus.fifo_full = (full_hold > 0) || ($urandom_range(99) < full_pct);
            if (full_hold > 0) full_hold--;
        end
    end

    // Monitor: reference arbitration model; pops the scoreboard on every push.
    initial begin
        int mg = 0;
        int ml = N - 1;
        int mcnt = 0;
        logic mbusy = 1'b0;
        logic mab = 1'b0;
        logic to, ep;
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_gnt", bus.gnt, 0);
                chk("rst_busy", bus.busy, 0);
                chk("rst_push", bus.fifo_push, 0);
                chk("rst_ready", bus.req_ready, 0);
                chk("rst_wdata", bus.fifo_wdata, 0);
                chk("rst_abort", bus.abort, 0);
                mbusy = 1'b0;
                ml = N - 1;
                mab = 1'b0;
                mcnt = 0;
            end else begin
                chk("abort", bus.abort, mab);
                if (bus.abort) naborts++;
                mab = 1'b0;
                if (!mbusy) begin
                    chk("idle_busy", bus.busy, 0);
                    chk("idle_gnt", bus.gnt, 0);
                    chk("idle_push", bus.fifo_push, 0);
                    chk("idle_wdata", bus.fifo_wdata, 0);
                    if (bus.req != 0) begin
                        mg = rr(bus.req, ml);
                        mbusy = 1'b1;
                        mcnt = 0;
                        gq.push_back(mg);
                    end
                end else begin
`ifdef ARB_TIMEOUT_EN
                    to = (mcnt == TO);
`else
                    to = 1'b0;
`endif
                    ep = bus.req_valid[mg] && !bus.fifo_full && !to;
                    chk("busy", bus.busy, 1);
                    chk("gnt", bus.gnt, 1 << mg);
                    chk("ready", bus.req_ready, (bus.fifo_full || to) ? 0 : (1 << mg));
                    chk("push", bus.fifo_push, ep);
                    chk("push_while_full", bus.fifo_push & bus.fifo_full, 0);
                    if (ep) begin
                        if (exp_q[mg].size() == 0) fail_now("unexpected_push");
                        else begin
                            e = exp_q[mg].pop_front();
                            chk("data", bus.fifo_wdata, e[7:0]);
                            npush++;
                            if (e[8]) begin
                                mbusy = 1'b0;
                                ml = mg;
                            end
                        end
                        mcnt = 0;
                    end else if (to) begin
                        mbusy = 1'b0;
                        ml = mg;
                        mab = 1'b1;
                    end else mcnt++;
                end
            end
        end
    end

    initial begin
        int p;
        cyc(2);
        for (int s = 0; s < N; s++) enq(s, 2, -1);
        cyc(2);
        @(posedge clk);
        #2 rst_n = 1'b1;
        drain(200);
        chk("order_len", gq.size(), 4);
        for (int k = 0; k < 4; k++) chk("order", gq[k], k);

        gq.delete();
        enq(2, 3, 'hA1);
        cyc(3);
        enq(0, 2, -1);
        drain(200);
        chk("lock_first", gq[0], 2);
        chk("lock_next", gq[1], 0);

        p = npush;
        enq(0, 3, -1);
        wait_push(20);
        full_hold = 5;
        drain(200);
        chk("stall_bytes", npush - p, 3);

        enq(3, 1, -1);
        drain(100);
        gq.delete();
        enq(0, 1, -1);
        enq(3, 1, -1);
        drain(100);
        chk("wrap_first", gq[0], 0);
        chk("wrap_next", gq[1], 3);

        vblock = 4'b0010;
        enq(1, 2, -1);
        enq(2, 2, -1);
        cyc(40);
`ifdef ARB_TIMEOUT_EN
        chk("abort_seen", naborts > 0, 1);
        chk("to_other_done", exp_q[2].size(), 0);
`else
        chk("hold_busy", bus.busy, 1);
        chk("hold_gnt", bus.gnt, 4'b0010);
        chk("hold_other", exp_q[2].size(), 2);
`endif
        vblock = '0;
        drain(300);

        valid_pct = 70;
        full_pct = 20;
        repeat (150) begin
            if ($urandom_range(2) == 0) enq($urandom_range(N - 1), $urandom_range(5, 1), -1);
            cyc($urandom_range(8, 1));
        end
        drain(3000);

        valid_pct = 100;
        full_pct = 0;
        enq(1, 6, -1);
        wait_push(20);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_gnt", bus.gnt, 0);
        chk("async_busy", bus.busy, 0);
        chk("async_push", bus.fifo_push, 0);
        chk("async_ready", bus.req_ready, 0);
        chk("async_wdata", bus.fifo_wdata, 0);
        chk("async_abort", bus.abort, 0);
        enq(3, 1, -1);
        gq.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        drain(200);
        chk("post_reset_gnt", gq[0], 1);

        for (int s = 0; s < N; s++) chk("exp_empty", exp_q[s].size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_push_arbiter.md
# fifo_push_arbiter

Round-robin arbiter sharing the single 8-bit push port of the system transmit FIFO between `N_REQ` byte-stream sources, such as sensor, clock and status reporters. Each source delivers a whole packet of one or more bytes terminated by `last`. The arbiter locks the grant for the whole packet, so packets never interleave in the FIFO. The FIFO `full` flag throttles the granted source. The block sits between the reporter modules and the FIFO write side (`push`, `push_Data`, `full`).

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `TIMEOUT`, 255: stall cycles before a grant is forcibly released (only with `ARB_TIMEOUT_EN`). Range 1..65535; counter is 16 bits.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  N_REQ  per-source request; held high while the source has a packet pending.
- `req_valid`  in  N_REQ  per-source byte valid.
- `req_last`  in  N_REQ  per-source flag marking the final byte of a packet; sampled with `req_valid`.
- `req_data`  in  8*N_REQ  per-source byte; source i occupies bits [8i+7:8i].
- `req_ready`  out  N_REQ  per-source byte accepted this cycle.
- `gnt`  out  N_REQ  one-hot grant, registered.
- `fifo_full`  in  1  FIFO full flag.
- `fifo_push`  out  1  FIFO push strobe.
- `fifo_wdata`  out  8  FIFO push data.
- `busy`  out  1  high while a grant is held.
- `abort`  out  1  one-cycle pulse when a grant is released by timeout.

## Operation
- FSM with two states: IDLE and GRANT. Register `last_gnt` holds the index of the last source granted.
- IDLE:
  - If any `req` bit is set, select the first set bit scanning upward from `last_gnt`+1 modulo `N_REQ`.
  - Register the one-hot `gnt` and move to GRANT.
  - If no `req` bit is set, stay in IDLE with `gnt`=0.
- GRANT, granted index g:
  - `req_ready[g]` = `!fifo_full`; all other `req_ready` bits are 0.
  - `fifo_push` = `req_valid[g] & !fifo_full`.
  - `fifo_wdata` = `req_data[g]`. When `gnt`=0, `fifo_wdata` is 0.
  - A transfer occurs on any cycle with `fifo_push`=1.
- A transfer with `req_last[g]`=1 ends the packet: on the next edge `last_gnt` takes g, `gnt` clears, and the FSM returns to IDLE.
- While in GRANT, `req` is ignored. Dropping `req` mid-packet does not release the grant; only `last` or a timeout does.
- `busy` = (state == GRANT).
- Valid and data from non-granted sources are ignored; those sources see `req_ready`=0.

## Timing
- Reset values: `gnt`=0, `req_ready`=0, `fifo_push`=0, `fifo_wdata`=0, `busy`=0, `abort`=0, `last_gnt`=`N_REQ`-1, so source 0 has first priority after reset. Asserting `rst_n` low mid-packet clears all of these immediately; a partial packet already in the FIFO is not recalled.
- Grant latency: `req` first sampled high at edge k gives `gnt` high after edge k. The first byte can transfer in cycle k+1.
- Throughput: one byte per cycle while `req_valid` is high and `fifo_full`=0.
- Packet gap: one IDLE cycle after each `last` transfer, including when the same source re-requests.
- A single-byte packet (`valid`+`last` in the first GRANT cycle) holds the grant for exactly one cycle.
- `fifo_full`=1 stalls with no push. The byte is offered again every cycle until full drops.
- Round-robin wrap: with `last_gnt`=`N_REQ`-1, the scan starts at source 0.
- `fifo_push` must never be high while `fifo_full` is high.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - A 16-bit stall counter runs in GRANT. It clears on every transfer and on entry to GRANT, and increments otherwise.
  - When the counter reaches `TIMEOUT`, the next edge clears `gnt`, sets `last_gnt`=g, pulses `abort` for one cycle and returns the FSM to IDLE. No push occurs on that cycle.
- `ARB_TIMEOUT_EN` undefined:
  - No counter exists and `abort` is tied to 0.
  - A stalled source holds the grant indefinitely.

## Test plan
- Reset with `req`=4'b1111: after reset release, `gnt` goes 0001, 0010, 0100, 1000 across four 2-byte packets. Each packet is followed by exactly one IDLE cycle, and the FIFO receives 8 bytes in source order.
- Source 2 sends 0xA1,0xA2,0xA3 (last) while source 0 requests mid-packet: the FIFO holds A1,A2,A3 contiguously, then source 0 is granted.
- `fifo_full` high for 5 cycles during byte 2 of a 3-byte packet: no push while full; byte 2 is pushed on the first cycle full is low; no byte is lost or duplicated.
- `last_gnt`=3 and `req`=4'b1001: source 0 is granted before source 3 (wrap-around).
- With `ARB_TIMEOUT_EN` and `TIMEOUT`=10, a granted source with `req_valid` held low: `abort` pulses once 11 cycles after the grant, and the other pending source is granted 1 cycle later. Without the macro, the grant is held and `abort` stays 0.
- `rst_n` pulsed low mid-packet: all outputs are 0 asynchronously, and the next grant goes to the lowest-index requester.
